spi_wb_multichan_ctrl: RTL and testbench



---
 rtl/spi_wb_multichan_pkg.sv | 23 ++
 rtl/spi_wb_multichan_ctrl_if.sv | 21 ++
 rtl/spi_wb_serialiser.sv | 106 ++++++++++
 rtl/spi_wb_multichan_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_wb_multichan_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_wb_multichan_pkg.sv
// Shared types and register layout for the multi-channel ADC serial-config controller.
package spi_wb_multichan_pkg;

  typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} eng_state_e;

  // Word indices (byte offset >> 2)
  localparam int unsigned WordCtrl   = 0;
  localparam int unsigned WordStatus = 1;
  localparam int unsigned WordCh0    = 2;

  // Field positions, value-bit numbering
  localparam int unsigned CtrlDivLsb = 16;
  localparam int unsigned StatOvfLsb = 8;
  localparam int unsigned StatActBit = 16;
  localparam int unsigned ChAddrLsb  = 16;
  localparam int unsigned ChStartBit = 31;

  function automatic int unsigned frame_w(input int unsigned pw, input int unsigned aw,
                                          input int unsigned dw);
    return pw + aw + dw;
  endfunction

endpackage

// File: rtl/spi_wb_multichan_ctrl_if.sv
// Wishbone slave bus bundle; bit 0 of each vector is the value MSB.
interface spi_wb_multichan_ctrl_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [0:3]  wb_sel_i;
  logic [0:31] wb_adr_i;
  logic [0:31] wb_data_i;
  logic [0:31] wb_data_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_data_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_data_o, wb_ack_o
  );
endinterface

// File: rtl/spi_wb_serialiser.sv
// Shared 3-wire frame engine: divider, LEAD/SHIFT/TRAIL sequencer and shift register.
// SPI_READBACK_EN adds a sample strobe for the last DataW shifted bits.
module spi_wb_serialiser
  import spi_wb_multichan_pkg::*;
#(
  parameter int unsigned FrameW = 32
`ifdef SPI_READBACK_EN
  ,
  parameter int unsigned DataW  = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [FrameW-1:0] frame_i,
  input  logic [7:0]        div_i,
  output logic              active_o,
  output logic              sclk_o,
  output logic              sdata_o,
  output logic              strobe_n_o
`ifdef SPI_READBACK_EN
  ,
  output logic              sample_o
`endif
);

  localparam int unsigned BitW = $clog2(FrameW);

  eng_state_e        state_q, state_d;
  logic [7:0]        hcnt_q, hcnt_d;
  logic [7:0]        div_q, div_d;
  logic              phase_q, phase_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              half_end, bit_end;

  assign half_end = (hcnt_q == div_q);
  assign bit_end  = half_end & phase_q;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    div_d    = div_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    frame_d  = frame_q;
    if (state_q != StIdle) begin
      if (half_end) begin
        hcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        hcnt_d = hcnt_q + 8'd1;
      end
    end
    case (state_q)
      StIdle: begin
        // Divider is latched here so a mid-frame DIV write cannot disturb timing
        if (start_i) begin
          state_d  = StLead;
          frame_d  = frame_i;
          div_d    = div_i;
          hcnt_d   = '0;
          phase_d  = 1'b0;
          bitcnt_d = '0;
        end
      end
      StLead:  if (bit_end) state_d = StShift;
      StShift: begin
        if (bit_end) begin
          frame_d  = frame_q << 1;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BitW'(FrameW - 1)) state_d = StTrail;
        end
      end
      StTrail: if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      hcnt_q   <= '0;
      div_q    <= '0;
      phase_q  <= 1'b0;
      bitcnt_q <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      frame_q  <= frame_d;
    end
  end

  assign active_o   = (state_q != StIdle);
  assign sclk_o     = active_o & phase_q;
  assign sdata_o    = (state_q == StShift) & frame_q[FrameW-1];
  assign strobe_n_o = (state_q != StShift);
`ifdef SPI_READBACK_EN
  assign sample_o   = (state_q == StShift) & bit_end & (bitcnt_q >= BitW'(FrameW - DataW));
`endif

endmodule

// File: rtl/spi_wb_multichan_ctrl.sv
// Wishbone slave driving N_CHAN ADC config ports through one round-robin shared serialiser.
// Optional SPI_READBACK_EN: adds spi_sdo_i; CHk reads return captured serial data.
module spi_wb_multichan_ctrl
  import spi_wb_multichan_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR  = 32'h0000_FFFF,
  parameter int unsigned N_CHAN      = 2,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned PREFIX_W    = 12,
  parameter int unsigned PREFIX      = 1,
  parameter int unsigned DIV_RST     = 7,
  parameter int unsigned RST_STRETCH = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  spi_wb_multichan_ctrl_if.slave wb,
  output logic [N_CHAN-1:0]     spi_clk_o,
  output logic [N_CHAN-1:0]     spi_data_o,
  output logic [N_CHAN-1:0]     spi_strobe_n_o,
  output logic [N_CHAN-1:0]     adc_reset_o,
  output logic [N_CHAN-1:0]     mmcm_reset_o
`ifdef SPI_READBACK_EN
  ,
  input  logic [N_CHAN-1:0]     spi_sdo_i
`endif
);

  localparam int unsigned FRAME_W = frame_w(PREFIX_W, ADDR_W, DATA_W);
  localparam int unsigned CW      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  logic [31:0] adr, off, wdat, bmask, rd;
  logic [3:0]  sel;
  logic [29:0] word;
  logic        req, wr, unused_bits;

  logic                ack_q, ack_d;
  logic [7:0]          div_q, div_d;
  logic [N_CHAN-1:0]   pending_q, pending_d, ovf_q, ovf_d, adc_rst_q, adc_rst_d, busy;
  logic [CW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d, gnt_idx, cand;
  logic [DATA_W-1:0]   data_q [N_CHAN];
  logic [DATA_W-1:0]   data_d [N_CHAN];
  logic [ADDR_W-1:0]   addr_q [N_CHAN];
  logic [ADDR_W-1:0]   addr_d [N_CHAN];
  logic [7:0]          cnt_q  [N_CHAN];
  logic [7:0]          cnt_d  [N_CHAN];
  logic                gnt_any, start;
  logic [FRAME_W-1:0]  frame;
  logic                eng_active, eng_sclk, eng_sdata, eng_strobe_n;

  // Reversed-index bus vectors land in value order on plain assignment
  assign adr  = wb.wb_adr_i;
  assign wdat = wb.wb_data_i;
  assign sel  = wb.wb_sel_i;
  assign off  = adr - C_BASEADDR;
  assign word = off[31:2];
  assign req  = wb.wb_cyc_i & wb.wb_stb_i & (off <= (C_HIGHADDR - C_BASEADDR));
  assign ack_d = req & ~ack_q;
  assign wr    = ack_q & wb.wb_we_i;
  assign bmask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  assign unused_bits = ^{wdat, off[1:0]};

  always_comb begin
    for (int k = 0; k < N_CHAN; k++) begin
      busy[k] = pending_q[k] | (eng_active & (gnt_q == CW'(k)));
    end
  end

  // Scan downwards so the lowest offset from the pointer wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      cand = CW'((32'(ptr_q) + i) % N_CHAN);
      if (pending_q[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign start = gnt_any & ~eng_active;
  assign frame = {PREFIX_W'(PREFIX), addr_q[gnt_idx], data_q[gnt_idx]};

  always_comb begin
    div_d     = div_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    data_d    = data_q;
    addr_d    = addr_q;
    adc_rst_d = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      cnt_d[k] = (cnt_q[k] != 8'd0) ? cnt_q[k] - 8'd1 : 8'd0;
    end
    if (start) begin
      gnt_d              = gnt_idx;
      ptr_d              = CW'((32'(gnt_idx) + 1) % N_CHAN);
      pending_d[gnt_idx] = 1'b0;
    end
    if (wr && word == 30'(WordCtrl)) begin
      if (sel[0]) begin
        for (int k = 0; k < N_CHAN; k++) begin
          if (wdat[k]) begin
            adc_rst_d[k] = 1'b1;
            cnt_d[k]     = 8'(RST_STRETCH);
          end
        end
      end
      if (sel[2]) div_d = wdat[CtrlDivLsb +: 8];
    end
    if (wr && word == 30'(WordStatus) && sel[1]) begin
      ovf_d = ovf_q & ~wdat[StatOvfLsb +: N_CHAN];
    end
    for (int k = 0; k < N_CHAN; k++) begin
      if (wr && word == 30'(WordCh0 + k)) begin
        if (busy[k]) begin
          ovf_d[k] = 1'b1;
        end else begin
          data_d[k] = (data_q[k] & ~bmask[DATA_W-1:0]) | (wdat[DATA_W-1:0] & bmask[DATA_W-1:0]);
          addr_d[k] = (addr_q[k] & ~bmask[ChAddrLsb +: ADDR_W]) |
                      (wdat[ChAddrLsb +: ADDR_W] & bmask[ChAddrLsb +: ADDR_W]);
          if (sel[3] && wdat[ChStartBit]) pending_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q     <= 1'b0;
      div_q     <= 8'(DIV_RST);
      pending_q <= '0;
      ovf_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      adc_rst_q <= '1;
      for (int k = 0; k < N_CHAN; k++) begin
        data_q[k] <= '0;
        addr_q[k] <= '0;
        cnt_q[k]  <= 8'(RST_STRETCH);
      end
    end else begin
      ack_q     <= ack_d;
      div_q     <= div_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      adc_rst_q <= adc_rst_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef SPI_READBACK_EN
  logic              eng_sample;
  logic [DATA_W-1:0] rdata_q [N_CHAN];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int k = 0; k < N_CHAN; k++) rdata_q[k] <= '0;
    end else if (eng_sample) begin
      rdata_q[gnt_q] <= DATA_W'({rdata_q[gnt_q], spi_sdo_i[gnt_q]});
    end
  end
`endif

  always_comb begin
    rd = '0;
    if (ack_q) begin
      if (word == 30'(WordCtrl)) rd[CtrlDivLsb +: 8] = div_q;
      if (word == 30'(WordStatus)) begin
        rd[N_CHAN-1:0]           = busy;
        rd[StatOvfLsb +: N_CHAN] = ovf_q;
        rd[StatActBit]           = eng_active;
      end
      for (int k = 0; k < N_CHAN; k++) begin
        if (word == 30'(WordCh0 + k)) begin
`ifdef SPI_READBACK_EN
          rd[DATA_W-1:0] = rdata_q[k];
`else
          rd[DATA_W-1:0] = data_q[k];
`endif
          rd[ChAddrLsb +: ADDR_W] = addr_q[k];
          rd[ChStartBit]          = busy[k];
        end
      end
    end
  end

  assign wb.wb_data_o = rd;
  assign wb.wb_ack_o  = ack_q;
  assign adc_reset_o  = adc_rst_q;

  always_comb begin
    for (int k = 0; k < N_CHAN; k++) begin
      spi_clk_o[k]      = eng_active & (gnt_q == CW'(k)) & eng_sclk;
      spi_data_o[k]     = eng_active & (gnt_q == CW'(k)) & eng_sdata;
      spi_strobe_n_o[k] = ~(eng_active & (gnt_q == CW'(k))) | eng_strobe_n;
      mmcm_reset_o[k]   = (cnt_q[k] != 8'd0);
    end
  end

  spi_wb_serialiser #(
    .FrameW (FRAME_W)
`ifdef SPI_READBACK_EN
    ,
    .DataW  (DATA_W)
`endif
  ) u_ser (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_n_i),
    .start_i    (start),
    .frame_i    (frame),
    .div_i      (div_q),
    .active_o   (eng_active),
    .sclk_o     (eng_sclk),
    .sdata_o    (eng_sdata),
    .strobe_n_o (eng_strobe_n)
`ifdef SPI_READBACK_EN
    ,
    .sample_o   (eng_sample)
`endif
  );

endmodule

// File: tb/tb_spi_wb_multichan_ctrl.sv
// Directed bench for spi_wb_multichan_ctrl with two channels, default parameters.
module tb_spi_wb_multichan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] spi_clk, spi_data, spi_strobe_n, adc_reset, mmcm_reset;
  int         checks = 0;
  int         failures = 0;

  logic [31:0] cap [2];
  int          nb [2];
  int          lowc [2];
  int          per [2];
  int          first_low [2];
  int          last_low [2];
  int          overlap;

  spi_wb_multichan_ctrl_if bus ();

  spi_wb_multichan_ctrl dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (rst_n),
    .wb             (bus),
    .spi_clk_o      (spi_clk),
    .spi_data_o     (spi_data),
    .spi_strobe_n_o (spi_strobe_n),
    .adc_reset_o    (adc_reset),
    .mmcm_reset_o   (mmcm_reset)
`ifdef SPI_READBACK_EN
    ,
    .spi_sdo_i      (2'b00)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    int n;
    @(posedge clk); #1;
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    bus.wb_we_i   = we;
    bus.wb_sel_i  = 4'hF;
    bus.wb_adr_i  = a;
    bus.wb_data_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.wb_ack_o !== 1'b1 && n < 16);
    check("ack", {31'd0, bus.wb_ack_o}, 32'd1);
    q = bus.wb_data_o;
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_cycle(1'b1, a, d, q);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_cycle(1'b0, a, 32'd0, q);
    check(tag, q, exp);
  endtask

  // Samples both channels at negedges; data captured on each sclk rise while strobe is low
  task automatic monitor(input int cycles);
    logic [1:0] pclk;
    int r1 [2];
    pclk = spi_clk;
    overlap = 0;
    for (int c = 0; c < 2; c++) begin
      cap[c] = '0; nb[c] = 0; lowc[c] = 0; per[c] = 0;
      first_low[c] = -1; last_low[c] = -1; r1[c] = -1;
    end
    for (int t = 0; t < cycles; t++) begin
      @(negedge clk);
      if (spi_strobe_n == 2'b00) overlap++;
      for (int c = 0; c < 2; c++) begin
        if (!spi_strobe_n[c]) begin
          lowc[c]++;
          if (first_low[c] < 0) first_low[c] = t;
          last_low[c] = t;
          if (spi_clk[c] && !pclk[c]) begin
            cap[c] = {cap[c][30:0], spi_data[c]};
            nb[c]++;
            if (r1[c] < 0) r1[c] = t;
            else if (per[c] == 0) per[c] = t - r1[c];
          end
        end
      end
      pclk = spi_clk;
    end
  endtask

  initial begin
    int n;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_sel_i = 4'h0; bus.wb_adr_i = '0; bus.wb_data_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", {30'd0, spi_strobe_n}, 32'h3);
    check("rst_mmcm", {30'd0, mmcm_reset}, 32'h3);
    check("rst_adc", {30'd0, adc_reset}, 32'h3);
    check("rst_sclk_data", {28'd0, spi_clk, spi_data}, 32'h0);
    check("rst_bus", {bus.wb_ack_o, bus.wb_data_o[1:31]}, 32'h0);
    rst_n = 1'b1;
    n = 0;
    while (mmcm_reset != 2'b00 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("mmcm_stretch_len", n, 255);
    check("adc_after_rst", {30'd0, adc_reset}, 32'h0);

    // Single frame at DIV=7
    rd_check("ctrl_rst", 32'h0, 32'h0007_0000);
    rd_check("status_rst", 32'h4, 32'h0);
    wr(32'h8, 32'h8003_A55A);
    rd_check("status_busy0", 32'h4, 32'h0001_0001);
    monitor(600);
    check("f0_bits", cap[0], 32'h0013_A55A);
    check("f0_nbits", nb[0], 32);
    check("f0_period", per[0], 16);
    check("f0_strobe_low", lowc[0], 512);
    check("f0_ch1_quiet", lowc[1], 0);
    rd_check("status_idle", 32'h4, 32'h0);
    rd_check("ch0_readback", 32'h8, 32'h0003_A55A);

    // Two back-to-back starts are serialised
    wr(32'h8, 32'h8002_1234);
    wr(32'hC, 32'h8004_5678);
    monitor(1200);
    check("rr_ch0_bits", cap[0], 32'h0012_1234);
    check("rr_ch1_bits", cap[1], 32'h0014_5678);
    check("rr_nbits", {nb[0][15:0], nb[1][15:0]}, {16'd32, 16'd32});
    check("rr_overlap", overlap, 0);
    check("rr_order", {31'd0, first_low[1] > last_low[0]}, 32'd1);

    // Write while busy is dropped and flagged
    wr(32'hC, 32'h8005_BEEF);
    wr(32'hC, 32'h8006_6666);
    repeat (600) @(negedge clk);
    rd_check("ovf_ch1_unchanged", 32'hC, 32'h0005_BEEF);
    rd_check("ovf_status", 32'h4, 32'h0000_0200);
    wr(32'h4, 32'h0000_0200);
    rd_check("ovf_cleared", 32'h4, 32'h0);

    // DIV=0, then a DIV write after grant must not change the running frame
    wr(32'h0, 32'h0000_0000);
    wr(32'h8, 32'h8001_000F);
    wr(32'h0, 32'h0003_0000);
    monitor(80);
    check("div0_bits", cap[0], 32'h0011_000F);
    check("div0_period", per[0], 2);
    check("div0_strobe_low", lowc[0], 64);
    wr(32'hC, 32'h8007_0001);
    monitor(300);
    check("div3_bits", cap[1], 32'h0017_0001);
    check("div3_period", per[1], 8);
    check("div3_strobe_low", lowc[1], 256);

    // Reset pulse on channel 1
    wr(32'h0, 32'h0003_0002);
    @(negedge clk);
    check("adc_pulse", {30'd0, adc_reset}, 32'h2);
    check("mmcm_reload", {30'd0, mmcm_reset}, 32'h2);
    n = 1;
    @(negedge clk);
    check("adc_pulse_end", {30'd0, adc_reset}, 32'h0);
    while (mmcm_reset[1] && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("mmcm1_len", n, 255);

    // Reset mid-SHIFT
    wr(32'h8, 32'h8008_AAAA);
    wr(32'hC, 32'h8009_0001);
    repeat (40) @(negedge clk);
    check("mid_shift", {30'd0, spi_strobe_n}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("arst_strobe", {30'd0, spi_strobe_n}, 32'h3);
    check("arst_sclk_data", {28'd0, spi_clk, spi_data}, 32'h0);
    check("arst_resets", {28'd0, adc_reset, mmcm_reset}, 32'hF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    monitor(600);
    check("no_resume", lowc[0] + lowc[1], 0);
    rd_check("status_after_rst", 32'h4, 32'h0);
    rd_check("ctrl_after_rst", 32'h0, 32'h0007_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
